// File: rtl/cache_line_fill_pkg.sv
// Shared types and constants for the cache line fill / store front end.
// Package name: cache_fill_pkg.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        LINE_WR = 2'd2,
        STORE   = 2'd3
    } fill_state_e;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_WIDTH     = 32;
    localparam int LINE_WIDTH     = WORDS_PER_LINE * WORD_WIDTH;
    localparam int LINE_BYTES     = LINE_WIDTH / 8;
    localparam int WORD_SEL_LSB   = 2;
    localparam int INDEX_LSB      = 4;

    // Moves a 4-bit word byte select into the byte lanes of the addressed word.
    function automatic logic [LINE_BYTES-1:0] lane_byte_enable(
        input logic [3:0] sel,
        input logic [1:0] word
    );
        logic [LINE_BYTES-1:0] be;
        be = {{(LINE_BYTES-4){1'b0}}, sel} << {word, 2'b00};
        return be;
    endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Wishbone-style read bus between the line fill engine (master) and memory (slave).
interface cache_line_fill_if;

    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;

    modport master (
        output cyc,
        output stb,
        output adr,
        input  dat,
        input  ack
    );

    modport slave (
        input  cyc,
        input  stb,
        input  adr,
        output dat,
        output ack
    );

endinterface

// File: rtl/cache_line_fill_buffer.sv
// Four-word line assembly buffer. o_line already contains the word being
// written this cycle, so the final beat can go straight to the SRAM register.
module line_fill_buffer
    import cache_fill_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [1:0]            i_wr_slot,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    output logic [LINE_WIDTH-1:0] o_line
);

    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_d;

    // Slot-addressed merge of the incoming bus word.
    always_comb begin
        line_d = line_q;
        if (i_wr_en) begin
            line_d[i_wr_slot*WORD_WIDTH +: WORD_WIDTH] = i_wr_data;
        end
    end

    // Buffer storage; contents are discarded by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign o_line = line_d;

endmodule

// File: rtl/cache_line_fill.sv
// Write-side front end of the cache data SRAM: line fills from the bus and
// store-hit lane writes. Optional build macro CACHE_CRITICAL_WORD_FIRST_EN
// starts each burst at the missed word and wraps; line slot placement is
// the same in both builds.
//
// state   | meaning
// IDLE    | waiting; a fill request beats a store request
// FILL    | burst read of 4 words, one per bus ack
// LINE_WR | one-cycle full-line SRAM write, done pulse
// STORE   | one-cycle byte-enabled store write, ack pulse
module cache_line_fill
    import cache_fill_pkg::*;
#(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,

    input  logic                      i_fill_req,
    input  logic [31:0]               i_fill_addr,
    output logic                      o_fill_busy,
    output logic                      o_fill_done,
    output logic [31:0]               o_fill_word,
    output logic                      o_fill_word_valid,

    input  logic                      i_wr_req,
    input  logic [31:0]               i_wr_addr,
    input  logic [31:0]               i_wr_data,
    input  logic [3:0]                i_wr_sel,
    output logic                      o_wr_ack,

    cache_line_fill_if.master         wb,

    output logic [ADDRESS_WIDTH-1:0]  o_sram_address,
    output logic [DATA_WIDTH-1:0]     o_sram_write_data,
    output logic                      o_sram_write_enable,
    output logic [DATA_WIDTH/8-1:0]   o_sram_byte_enable
);

    fill_state_e               state_q, state_d;
    logic [1:0]                beat_q, beat_d;
    logic [1:0]                req_word_q, req_word_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [31:0]               fill_word_q, fill_word_d;
    logic                      fill_word_valid_q, fill_word_valid_d;
    logic                      wr_ack_q, wr_ack_d;
    logic                      cyc_q, cyc_d;
    logic [31:0]               adr_q, adr_d;
    logic [ADDRESS_WIDTH-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]     sram_wdata_q, sram_wdata_d;
    logic                      sram_we_q, sram_we_d;
    logic [DATA_WIDTH/8-1:0]   sram_be_q, sram_be_d;

    logic                      buf_wr_en;
    logic [LINE_WIDTH-1:0]     line_next;
    logic [1:0]                first_word;
    logic                      unused_addr_bits;

    // Word that opens each burst.
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign first_word = i_fill_addr[3:2];
`else
    assign first_word = 2'd0;
`endif

    // Byte offset bits and address bits above the line index play no part here.
    assign unused_addr_bits = ^{i_fill_addr[1:0], i_wr_addr[1:0],
                                i_wr_addr[31:ADDRESS_WIDTH+INDEX_LSB]};

    line_fill_buffer u_buffer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (buf_wr_en),
        .i_wr_slot (adr_q[3:2]),
        .i_wr_data (wb.dat),
        .o_line    (line_next)
    );

    // Next-state and next-output logic; strobes default low, everything else holds.
    always_comb begin
        state_d           = state_q;
        beat_d            = beat_q;
        req_word_d        = req_word_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        fill_word_d       = fill_word_q;
        fill_word_valid_d = 1'b0;
        wr_ack_d          = 1'b0;
        cyc_d             = cyc_q;
        adr_d             = adr_q;
        sram_addr_d       = sram_addr_q;
        sram_wdata_d      = sram_wdata_q;
        sram_we_d         = 1'b0;
        sram_be_d         = sram_be_q;
        buf_wr_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_fill_req) begin
                    state_d    = FILL;
                    beat_d     = 2'd0;
                    req_word_d = i_fill_addr[3:2];
                    busy_d     = 1'b1;
                    cyc_d      = 1'b1;
                    adr_d      = {i_fill_addr[31:INDEX_LSB], first_word, 2'b00};
                end else if (i_wr_req) begin
                    state_d      = STORE;
                    wr_ack_d     = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = i_wr_addr[ADDRESS_WIDTH+INDEX_LSB-1:INDEX_LSB];
                    sram_wdata_d = {WORDS_PER_LINE{i_wr_data}};
                    sram_be_d    = lane_byte_enable(i_wr_sel, i_wr_addr[3:2]);
                end
            end

            FILL: begin
                if (wb.ack) begin
                    // adr_q[3:2] is the word being acked, which is also its slot.
                    buf_wr_en = 1'b1;
                    beat_d    = beat_q + 2'd1;
                    adr_d     = {adr_q[31:INDEX_LSB], adr_q[3:2] + 2'd1, 2'b00};
                    if (adr_q[3:2] == req_word_q) begin
                        fill_word_d       = wb.dat;
                        fill_word_valid_d = 1'b1;
                    end
                    if (beat_q == 2'd3) begin
                        state_d      = LINE_WR;
                        cyc_d        = 1'b0;
                        done_d       = 1'b1;
                        sram_we_d    = 1'b1;
                        sram_addr_d  = adr_q[ADDRESS_WIDTH+INDEX_LSB-1:INDEX_LSB];
                        sram_wdata_d = line_next;
                        sram_be_d    = '1;
                    end
                end
            end

            LINE_WR: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            STORE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus cycle immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q           <= IDLE;
            beat_q            <= 2'd0;
            req_word_q        <= 2'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            fill_word_q       <= '0;
            fill_word_valid_q <= 1'b0;
            wr_ack_q          <= 1'b0;
            cyc_q             <= 1'b0;
            adr_q             <= '0;
            sram_addr_q       <= '0;
            sram_wdata_q      <= '0;
            sram_we_q         <= 1'b0;
            sram_be_q         <= '0;
        end else begin
            state_q           <= state_d;
            beat_q            <= beat_d;
            req_word_q        <= req_word_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            fill_word_q       <= fill_word_d;
            fill_word_valid_q <= fill_word_valid_d;
            wr_ack_q          <= wr_ack_d;
            cyc_q             <= cyc_d;
            adr_q             <= adr_d;
            sram_addr_q       <= sram_addr_d;
            sram_wdata_q      <= sram_wdata_d;
            sram_we_q         <= sram_we_d;
            sram_be_q         <= sram_be_d;
        end
    end

    assign o_fill_busy         = busy_q;
    assign o_fill_done         = done_q;
    assign o_fill_word         = fill_word_q;
    assign o_fill_word_valid   = fill_word_valid_q;
    assign o_wr_ack            = wr_ack_q;
    assign wb.cyc              = cyc_q;
    assign wb.stb              = cyc_q;
    assign wb.adr              = adr_q;
    assign o_sram_address      = sram_addr_q;
    assign o_sram_write_data   = sram_wdata_q;
    assign o_sram_write_enable = sram_we_q;
    assign o_sram_byte_enable  = sram_be_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: stimulus queues expected SRAM writes,
// fill words and bus beats; the bus slave and the output monitor pop them.
`timescale 1ns/1ps
module tb_cache_line_fill;

    typedef struct {
        logic [6:0]   addr;
        logic [127:0] data;
        logic [15:0]  be;
        bit           is_fill;
        int           due;
    } sram_exp_t;

    typedef struct {
        logic [31:0] word;
        int          due;
    } word_exp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          wt;
    } beat_t;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_fill_req;
    logic [31:0]  i_fill_addr;
    logic         o_fill_busy;
    logic         o_fill_done;
    logic [31:0]  o_fill_word;
    logic         o_fill_word_valid;
    logic         i_wr_req;
    logic [31:0]  i_wr_addr;
    logic [31:0]  i_wr_data;
    logic [3:0]   i_wr_sel;
    logic         o_wr_ack;
    logic [6:0]   o_sram_address;
    logic [127:0] o_sram_write_data;
    logic         o_sram_write_enable;
    logic [15:0]  o_sram_byte_enable;

    cache_line_fill_if wb_if ();

    cache_line_fill dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_fill_req          (i_fill_req),
        .i_fill_addr         (i_fill_addr),
        .o_fill_busy         (o_fill_busy),
        .o_fill_done         (o_fill_done),
        .o_fill_word         (o_fill_word),
        .o_fill_word_valid   (o_fill_word_valid),
        .i_wr_req            (i_wr_req),
        .i_wr_addr           (i_wr_addr),
        .i_wr_data           (i_wr_data),
        .i_wr_sel            (i_wr_sel),
        .o_wr_ack            (o_wr_ack),
        .wb                  (wb_if),
        .o_sram_address      (o_sram_address),
        .o_sram_write_data   (o_sram_write_data),
        .o_sram_write_enable (o_sram_write_enable),
        .o_sram_byte_enable  (o_sram_byte_enable)
    );

    sram_exp_t sram_q[$];
    word_exp_t word_q[$];
    beat_t     beat_q[$];

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc_n        = 0;
    int done_seen    = 0;
    int exp_done     = 0;
    int acks_sampled = 0;

    logic        ack_prev = 1'b0;
    logic [31:0] dat_prev = '0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc_n    <= cyc_n + 1;
        ack_prev <= wb_if.ack;
        dat_prev <= wb_if.dat;
        if (i_rst_n && wb_if.cyc && wb_if.ack) acks_sampled++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Bus slave: serves queued beats with their wait states, checks the address.
    beat_t cur;
    bit    have_cur = 1'b0;
    int    wcnt     = 0;
    always @(negedge i_clk) begin
        wb_if.ack = 1'b0;
        wb_if.dat = $urandom();
        if (!i_rst_n) begin
            have_cur = 1'b0;
        end else if (wb_if.cyc && wb_if.stb) begin
            if (!have_cur && beat_q.size() > 0) begin
                cur      = beat_q.pop_front();
                have_cur = 1'b1;
                wcnt     = cur.wt;
            end
            if (have_cur) begin
                if (wcnt > 0) begin
                    wcnt--;
                end else begin
                    chk("bus_adr", wb_if.adr, cur.adr);
                    wb_if.dat = cur.dat;
                    wb_if.ack = 1'b1;
                    have_cur  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every SRAM write and fill-word pulse is matched to the queues.
    sram_exp_t m_se;
    word_exp_t m_we;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_sram_write_enable) begin
                if (sram_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sram_unexpected: write to 0x%0h, required no write", o_sram_address);
                end else begin
                    m_se = sram_q.pop_front();
                    chk("sram_address", o_sram_address, m_se.addr);
                    chk("sram_data", o_sram_write_data, m_se.data);
                    chk("sram_be", o_sram_byte_enable, m_se.be);
                    chk("fill_done_flag", o_fill_done, m_se.is_fill);
                    chk("wr_ack_flag", o_wr_ack, !m_se.is_fill);
                    if (m_se.due >= 0) chk("sram_cycle", cyc_n, m_se.due);
                end
            end else if (o_fill_done || o_wr_ack) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_without_write: done=%0b ack=%0b, required 0 without write_enable",
                         o_fill_done, o_wr_ack);
            end
            if (o_fill_done) done_seen++;
            if (o_fill_word_valid) begin
                if (word_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fill_word_unexpected: word 0x%0h, required no pulse", o_fill_word);
                end else begin
                    m_we = word_q.pop_front();
                    chk("fill_word", o_fill_word, m_we.word);
                    chk("fill_word_after_ack", {ack_prev, dat_prev}, {1'b1, m_we.word});
                    if (m_we.due >= 0) chk("fill_word_cycle", cyc_n, m_we.due);
                end
            end
        end
    end

    // Queues beats and expectations for one fill, then pulses the request.
    task automatic start_fill(input logic [31:0] addr, input logic [127:0] line,
                              input bit timed, input int maxwait, input bit expect_write);
        int         c;
        int         p;
        logic [1:0] k;
        logic [1:0] w;
        c = cyc_n;
        p = 0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        k = addr[3:2];
`else
        k = 2'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            w = k + i[1:0];
            beat_q.push_back(beat_t'{{addr[31:4], w, 2'b00}, line[32*w +: 32],
                                     timed ? 0 : int'($urandom_range(0, maxwait))});
            if (w == addr[3:2]) p = i;
        end
        if (expect_write) begin
            sram_q.push_back(sram_exp_t'{addr[10:4], line, 16'hFFFF, 1'b1, timed ? c + 5 : -1});
            exp_done++;
        end
        if (expect_write || p == 0) begin
            word_q.push_back(word_exp_t'{line[32*addr[3:2] +: 32], timed ? c + 2 + p : -1});
        end
        i_fill_req  = 1'b1;
        i_fill_addr = addr;
        @(negedge i_clk);
        i_fill_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!o_fill_done && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_fill_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_timeout: no done within %0d cycles, required done pulse", limit);
        end
        @(negedge i_clk);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel,
                            input logic [15:0] exp_be, input int rel);
        int n;
        sram_q.push_back(sram_exp_t'{addr[10:4], {4{data}}, exp_be, 1'b0, cyc_n + rel});
        i_wr_req  = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        i_wr_sel  = sel;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_wr_ack && n < 20);
        if (!o_wr_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL store_timeout: no ack for addr 0x%0h, required ack", addr);
        end
        i_wr_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int target;
        logic [31:0]  ra;
        logic [127:0] rl;

        i_rst_n     = 1'b0;
        i_fill_req  = 1'b0;
        i_fill_addr = '0;
        i_wr_req    = 1'b0;
        i_wr_addr   = '0;
        i_wr_data   = '0;
        i_wr_sel    = '0;
        wb_if.ack   = 1'b0;
        wb_if.dat   = '0;

        repeat (3) @(negedge i_clk);
        chk("reset_fill_flags", {o_fill_busy, o_fill_done, o_fill_word_valid, o_wr_ack}, 0);
        chk("reset_fill_word", o_fill_word, 0);
        chk("reset_bus", {wb_if.cyc, wb_if.stb, wb_if.adr}, 0);
        chk("reset_sram_ctl", {o_sram_write_enable, o_sram_address, o_sram_byte_enable}, 0);
        chk("reset_sram_data", o_sram_write_data, 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Miss at 0x128 with zero wait states; a second request mid-fill is ignored.
        start_fill(32'h0000_0128, {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 1'b1, 0, 1'b1);
        chk("busy_during_fill", o_fill_busy, 1'b1);
        i_fill_req = 1'b1;
        @(negedge i_clk);
        i_fill_req = 1'b0;
        wait_done(40);
        chk("busy_after_fill", o_fill_busy, 1'b0);
        chk("fill_word_held", o_fill_word, 32'h0000_00A2);

        // Stores: lane placement, back-to-back rate, empty byte select.
        do_store(32'h0000_0034, 32'hDEAD_BEEF, 4'b0011, 16'h0030, 1);
        do_store(32'h0000_0038, 32'hDEAD_BEEF, 4'b0011, 16'h0300, 2);
        do_store(32'h0000_0030, 32'h5555_AAAA, 4'b0000, 16'h0000, 2);
        @(negedge i_clk);
        do_store(32'h0000_07F4, 32'hCAFE_F00D, 4'b1001, 16'h0090, 1);
        @(negedge i_clk);

        // Fill and store requested together: fill first, store acked two cycles after done.
        c = cyc_n;
        i_wr_req  = 1'b1;
        i_wr_addr = 32'h0000_205C;
        i_wr_data = 32'h1234_5678;
        i_wr_sel  = 4'b1111;
        start_fill(32'h0000_2050, {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0}, 1'b1, 0, 1'b1);
        sram_q.push_back(sram_exp_t'{7'h05, {4{32'h1234_5678}}, 16'hF000, 1'b0, c + 7});
        n = 0;
        while (!o_wr_ack && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        chk("pending_store_ack", o_wr_ack, 1'b1);
        i_wr_req = 1'b0;
        @(negedge i_clk);

        // Reset after the second ack of a fill, then a clean fill.
        target = acks_sampled + 2;
        start_fill(32'h0000_0FCC, {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0}, 1'b1, 0, 1'b0);
        n = 0;
        while (acks_sampled < target && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("fill_active_before_reset", wb_if.cyc, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("reset_drops_cyc_stb", {wb_if.cyc, wb_if.stb}, 0);
        chk("reset_no_write", {o_sram_write_enable, o_fill_done, o_fill_busy}, 0);
        beat_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        start_fill(32'h0000_0128, {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0}, 1'b1, 0, 1'b1);
        wait_done(40);
        chk("fill_word_after_reset", o_fill_word, 32'h0000_00C2);

        // Random wait states on 100 fills.
        for (int i = 0; i < 100; i++) begin
            ra = $urandom();
            rl = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_fill(ra, rl, 1'b0, 5, 1'b1);
            wait_done(200);
        end

        repeat (3) @(negedge i_clk);
        chk("done_count", done_seen, exp_done);
        chk("sram_queue_empty", sram_q.size(), 0);
        chk("word_queue_empty", word_q.size(), 0);
        chk("beat_queue_empty", beat_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
